seq_pattern_tx: RTL and testbench

//  Serial bit-pattern transmitter: the drive side of the single-bit serial input x used by our

---
 rtl/seq_pattern_tx.sv | 146 ++++++++++++++
 tb/tb_seq_pattern_tx.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_tx.sv
// Serial bit-pattern transmitter: shifts a captured pattern out MSB-first, idles GAP_CYC cycles, pulses done.
// Optional SEQ_TX_REPEAT_EN adds a repeat_en input that loops the captured pattern instead of finishing.
module seq_pattern_tx #(
   parameter int PAT_W   = 8,
   parameter int GAP_CYC = 2
) (
   input  logic                       CLK,
   input  logic                       RESET,
   input  logic                       start,
   input  logic [PAT_W-1:0]           pattern,
   input  logic [$clog2(PAT_W+1)-1:0] len,
`ifdef SEQ_TX_REPEAT_EN
   input  logic                       repeat_en,
`endif
   output logic                       x,
   output logic                       x_valid,
   output logic                       busy,
   output logic                       done,
   output logic [2:0]                 S
);

   localparam int LW = $clog2(PAT_W+1);
   localparam int GW = (GAP_CYC > 0) ? $clog2(GAP_CYC+1) : 1;
   localparam logic [LW-1:0] PAT_W_L = LW'(PAT_W);
   localparam logic [GW-1:0] GAP_L   = GW'(GAP_CYC);

   typedef enum logic [2:0] {
      IDLE  = 3'b000,
      SHIFT = 3'b001,
      GAP   = 3'b010,
      DONE  = 3'b011
   } state_t;

   state_t           state, state_n;
   logic [PAT_W-1:0] shreg, shreg_n;
   logic [PAT_W-1:0] cap, cap_n;
   logic [LW-1:0]    clen, clen_n;
   logic [LW-1:0]    cnt, cnt_n;
   logic [GW-1:0]    gcnt, gcnt_n;
   logic             x_n;
   logic [LW-1:0]    leff;
   logic [PAT_W-1:0] aligned;
   logic             rpt;

`ifdef SEQ_TX_REPEAT_EN
   assign rpt = repeat_en;
`else
   assign rpt = 1'b0;
`endif

   // Left-justify the pattern so bit L-1 sits at the MSB and every send shifts from the top.
   assign leff    = (len == '0 || len > PAT_W_L) ? PAT_W_L : len;
   assign aligned = pattern << (PAT_W_L - leff);

   always_comb begin
      state_n = state;
      shreg_n = shreg;
      cap_n   = cap;
      clen_n  = clen;
      cnt_n   = cnt;
      gcnt_n  = gcnt;
      x_n     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               shreg_n = aligned;
               cap_n   = aligned;
               clen_n  = leff;
               cnt_n   = LW'(1);
               x_n     = aligned[PAT_W-1];
               state_n = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt < clen) begin
               shreg_n = shreg << 1;
               x_n     = shreg[PAT_W-2];
               cnt_n   = cnt + 1'b1;
            end else if (GAP_CYC > 0) begin
               gcnt_n  = GW'(1);
               state_n = GAP;
            end else if (rpt) begin
               shreg_n = cap;
               cnt_n   = LW'(1);
               x_n     = cap[PAT_W-1];
            end else begin
               state_n = DONE;
            end
         end
         GAP: begin
            if (gcnt < GAP_L) begin
               gcnt_n = gcnt + 1'b1;
            end else if (rpt) begin
               // Repeat reloads the captured copy; live pattern/len are not re-sampled.
               shreg_n = cap;
               cnt_n   = LW'(1);
               x_n     = cap[PAT_W-1];
               state_n = SHIFT;
            end else begin
               state_n = DONE;
            end
         end
         DONE: begin
            cnt_n   = '0;
            gcnt_n  = '0;
            state_n = IDLE;
         end
         default: begin
            shreg_n = '0;
            cnt_n   = '0;
            gcnt_n  = '0;
            state_n = IDLE;
         end
      endcase
   end

   // Outputs are registered from the next-state decode so they line up with S.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state   <= IDLE;
         shreg   <= '0;
         cap     <= '0;
         clen    <= '0;
         cnt     <= '0;
         gcnt    <= '0;
         x       <= 1'b0;
         x_valid <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         state   <= state_n;
         shreg   <= shreg_n;
         cap     <= cap_n;
         clen    <= clen_n;
         cnt     <= cnt_n;
         gcnt    <= gcnt_n;
         x       <= x_n;
         x_valid <= (state_n == SHIFT);
         busy    <= (state_n != IDLE);
         done    <= (state_n == DONE);
      end
   end

   assign S = state;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx (PAT_W=8, GAP_CYC=2): vector table plus reset/busy/repeat sequences.
module tb_seq_pattern_tx;

   logic       CLK = 1'b0;
   logic       RESET = 1'b1;
   logic       start = 1'b0;
   logic [7:0] pattern = '0;
   logic [3:0] len = '0;
`ifdef SEQ_TX_REPEAT_EN
   logic       repeat_en = 1'b0;
`endif
   logic       x, x_valid, busy, done;
   logic [2:0] S;

   int npass = 0;
   int ntot  = 0;
   logic [2:0] strace [0:63];

   always #5 CLK = ~CLK;

   seq_pattern_tx #(.PAT_W(8), .GAP_CYC(2)) dut (
      .CLK(CLK), .RESET(RESET), .start(start), .pattern(pattern), .len(len),
`ifdef SEQ_TX_REPEAT_EN
      .repeat_en(repeat_en),
`endif
      .x(x), .x_valid(x_valid), .busy(busy), .done(done), .S(S)
   );

   typedef struct {
      logic [7:0] pat;
      logic [3:0] len;
      logic [7:0] exp_bits;
      int         exp_n;
      int         exp_hits;
   } vec_t;
   vec_t vt [7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntot++;
      if (act === exp) npass++;
      else $display("FAIL %s: got %0h want %0h", nm, act, exp);
   endtask

   // One send: start pulsed for one cycle, poke[c] drives start during cycle c; sampled on negedges.
   task automatic send(input logic [7:0] p, input logic [3:0] l, input logic [63:0] poke,
                       output logic [15:0] bits, output int nv, output int nb, output int dc,
                       output int hits, output logic tmo);
      logic [3:0] hist;
      logic idle;
      bits = '0; nv = 0; nb = 0; dc = 0; hits = 0; hist = '0; idle = 1'b0;
      @(negedge CLK);
      pattern = p; len = l; start = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge CLK);
         start = poke[c];
         strace[c] = S;
         if (x_valid) begin
            bits = {bits[14:0], x};
            nv++;
            hist = {hist[2:0], x};
            if (nv >= 4 && hist == 4'b0110) hits++;
         end
         if (busy) nb++;
         if (done) dc = c;
         if (!busy) begin
            idle = 1'b1;
            break;
         end
      end
      start = 1'b0;
      tmo = ~idle;
   endtask

   initial begin
      logic [15:0] bits;
      int nv, nb, dc, hits;
      logic tmo, ok;

      vt[0] = '{8'b1011_0010, 4'd8,  8'hB2, 8, 1};
      vt[1] = '{8'hFF,        4'd3,  8'h07, 3, 0};
      vt[2] = '{8'h5A,        4'd0,  8'h5A, 8, 1};
      vt[3] = '{8'h06,        4'd4,  8'h06, 4, 1};
      vt[4] = '{8'h01,        4'd1,  8'h01, 1, 0};
      vt[5] = '{8'hC3,        4'd15, 8'hC3, 8, 0};
      vt[6] = '{8'hA5,        4'd5,  8'h05, 5, 0};

      // Reset state, then 10 idle cycles with no start
      repeat (3) @(negedge CLK);
      chk("rst_outs", {25'd0, S, x, x_valid, busy, done}, 32'd0);
      RESET = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge CLK);
         chk("idle_outs", {25'd0, S, x, x_valid, busy, done}, 32'd0);
      end

      for (int i = 0; i < 7; i++) begin
         send(vt[i].pat, vt[i].len, 64'd0, bits, nv, nb, dc, hits, tmo);
         chk("vec_timeout", {31'd0, tmo}, 32'd0);
         chk("vec_bits", {24'd0, bits[7:0]}, {24'd0, vt[i].exp_bits});
         chk("vec_nvalid", nv, vt[i].exp_n);
         chk("vec_busy_len", nb, vt[i].exp_n + 3);
         chk("vec_done_cyc", dc, vt[i].exp_n + 3);
         chk("vec_det_hits", hits, vt[i].exp_hits);
         if (i == 0) begin
            chk("s_shift", {29'd0, strace[1]}, 32'd1);
            chk("s_gap",   {29'd0, strace[9]}, 32'd2);
            chk("s_done",  {29'd0, strace[11]}, 32'd3);
         end
      end

      // start pulses during SHIFT, GAP and DONE are ignored
      send(8'hB2, 4'd8, (64'd1 << 3) | (64'd1 << 9) | (64'd1 << 11), bits, nv, nb, dc, hits, tmo);
      chk("poke_busy_len", nb, 11);
      chk("poke_done_cyc", dc, 11);
      chk("poke_bits", {16'd0, bits}, 32'h00B2);
      ok = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         if (busy || x_valid) ok = 1'b0;
      end
      chk("poke_no_restart", {31'd0, ok}, 32'd1);

      // start held high: next pattern's first bit one cycle after IDLE
      send(8'h80, 4'd8, {64{1'b1}}, bits, nv, nb, dc, hits, tmo);
      chk("b2b_first_busy", nb, 11);
      start = 1'b1;
      pattern = 8'h80; len = 4'd8;
      @(negedge CLK);
      start = 1'b0;
      chk("b2b_next_shift", {28'd0, S, x_valid}, {28'd0, 3'b001, 1'b1});
      chk("b2b_next_x", {31'd0, x}, 32'd1);
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         if (!busy) begin ok = 1'b1; break; end
      end
      chk("b2b_drain", {31'd0, ok}, 32'd1);

      // Async reset during the 4th SHIFT cycle
      @(negedge CLK);
      pattern = 8'hB2; len = 4'd8; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      repeat (3) @(negedge CLK);
      chk("pre_rst_x", {28'd0, S, x}, {28'd0, 3'b001, 1'b1});
      #2 RESET = 1'b1;
      #1 chk("async_rst_outs", {25'd0, S, x, x_valid, busy, done}, 32'd0);
      @(negedge CLK);
      RESET = 1'b0;
      ok = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge CLK);
         if (x_valid || busy || S != 3'b000) ok = 1'b0;
      end
      chk("post_rst_quiet", {31'd0, ok}, 32'd1);

`ifdef SEQ_TX_REPEAT_EN
      // Repeat: 0110 loops with a 2-cycle gap, no done until repeat_en drops
      begin
         logic [3:0] hist;
         hist = '0; bits = '0; nv = 0; hits = 0; dc = 0; ok = 1'b1;
         repeat_en = 1'b1;
         @(negedge CLK);
         pattern = 8'h06; len = 4'd4; start = 1'b1;
         for (int c = 1; c <= 30; c++) begin
            @(negedge CLK);
            start = 1'b0;
            if (x_valid) begin
               bits = {bits[14:0], x};
               nv++;
               hist = {hist[2:0], x};
               if (nv >= 4 && hist == 4'b0110) hits++;
            end
            if (c <= 18 && (done || !busy)) ok = 1'b0;
            if (done) dc = c;
            if (c == 18) repeat_en = 1'b0;
            if (c > 18 && !busy) break;
         end
         chk("rpt_no_done", {31'd0, ok}, 32'd1);
         chk("rpt_bits", {16'd0, bits}, 32'h0666);
         chk("rpt_nvalid", nv, 12);
         chk("rpt_det_hits", hits, 3);
         chk("rpt_done_cyc", dc, 19);
      end
`endif

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

endmodule
